baseline_hist_tracker: RTL and testbench
========================================

// Module: baseline_hist_tracker
// PURPOSE
// Parametrised baseline-drift histogrammer. Bins ADC samples around center_val into a
// 2^BIN_AW-bin RAM histogram (generalised bin width, depth, count width). Tracks the peak
// (mode) bin on the fly to produce a baseline estimate, and halves the histogram instead of
// stalling when a bin fills. Sits between the ADC front end and the slow-control readout.
// PARAMETERS
// ADC_W     14  ADC sample / center_val / baseline width
// BIN_AW     5  bin address width; NBINS = 2**BIN_AW; bins 0 and NBINS-1 are overflow bins
// CNT_W     20  per-bin count width; CMAX = 2**CNT_W-1
// BIN_SHIFT  0  bin width = 2**BIN_SHIFT ADC codes
// PORTS
// clk         in   1       clock
// rst_n       in   1       reset, asynchronous, active-low
// clear       in   1       synchronous request: zero the histogram
// pause       in   1       stop accumulation; enable readout
// rescale_en  in   1       1: halve all bins on full; 0: saturate and flag filled
// center_val  in   ADC_W   histogram centre, unsigned
// adc         in   ADC_W   sample, unsigned
// adc_valid   in   1       sample strobe
// rd_addr     in   BIN_AW  readout bin address (PAUSE only)
// rd_data     out  CNT_W   readout count
// rd_valid    out  1       rd_data valid
// peak_bin    out  BIN_AW  current mode bin
// peak_cnt    out  CNT_W   count of peak_bin
// baseline    out  ADC_W   center_val + ((peak_bin-NBINS/2) <<< BIN_SHIFT), clamped 0..2**ADC_W-1
// filled      out  1       sticky: a bin reached CMAX with rescale_en=0
// busy        out  1       high in CLEAR/HALVE; samples are dropped
// BEHAVIOUR
// - Reset: state CLEAR, clear counter 0; rd_data=0, rd_valid=0, peak_bin=NBINS/2, peak_cnt=0,
//   filled=0, busy=1. Reset asserted mid-operation aborts anything and restarts CLEAR.
// - Bin map: d = $signed({1'b0,adc}) - $signed({1'b0,center_val}) (ADC_W+1 bits);
//   b = (d >>> BIN_SHIFT) + NBINS/2; b<0 -> 0, b>NBINS-1 -> NBINS-1.
// - States: CLEAR, RUN, DRAIN, PAUSE, HALVE.
//   CLEAR: writes 0 to bins 0..NBINS-1, one bin/cycle (NBINS cycles), clears filled,
//     resets peak, latches center_val, -> RUN.
//   RUN: pipeline S0 bin register -> S1 RAM read -> S2 write cnt+1. A sample taken at edge N is
//     written at edge N+2. Back-to-back or every-other same-bin hits use forwarding from S2/write
//     data (no counts lost, no per-pattern special cases). Priority of exits: clear or
//     center_val != latched -> CLEAR; full event -> HALVE (rescale_en=1); pause -> DRAIN.
//   DRAIN: no new samples; 2 cycles to flush S1/S2; -> PAUSE.
//   PAUSE: rd_data = RAM[rd_addr], 1-cycle latency, rd_valid=1 from the 2nd PAUSE cycle;
//     pause low -> RUN (rd_valid=0). clear or center change in PAUSE -> CLEAR.
//   HALVE: entered when an increment would make a bin exceed CMAX-1 (written value == CMAX).
//     Pipeline flushed first; then each bin <- bin>>1 in NBINS+2 cycles (read, shift, write);
//     peak_cnt <- peak_cnt>>1; peak_bin kept; -> RUN. Samples in HALVE are dropped.
// - Saturation (rescale_en=0): count stays at CMAX, filled set and held until CLEAR.
// - Peak: on each S2 write of count c to bin b: if c > peak_cnt or b == peak_bin, then
//   peak_bin<=b, peak_cnt<=c. Ties keep the incumbent. Overflow bins take part.
// - busy = (state==CLEAR)||(state==HALVE); adc_valid while busy/DRAIN/PAUSE is ignored.
// TESTING
// - Reset, center=1000, 10 samples adc=1003 -> after drain, pause, rd_addr=19 reads 10; peak_bin=19, baseline=1003.
// - 8 alternating samples 1000,1001 then 3x 1000 -> bins 16/17 read 7/4; nothing lost to RMW hazard.
// - BIN_SHIFT=2, center=500, adc=0 and adc=16383 -> bins 0 and 31 each +1; adc=507 -> bin 17.
// - CNT_W=4, rescale_en=1, 15 hits to bin 16 -> HALVE, bin 16 reads 7, peak_cnt=7, busy for 34 cycles.
// - CNT_W=4, rescale_en=0, 20 hits to bin 5 -> bin 5 reads 15, filled=1 until clear pulse.
// - center_val changed mid-stream, and rst_n dropped mid-HALVE -> CLEAR, all bins read 0, peak reset.

Source files
------------

// File: rtl/baseline_hist_tracker_if.sv
// Sample and readout bus of the baseline histogrammer.
//   adc / adc_valid : ADC sample stream into the histogrammer
//   rd_addr         : readout bin address (honoured while paused)
//   rd_data/rd_valid: readout count and its valid flag
// master = front end / slow control side, slave = histogrammer.
interface baseline_hist_tracker_if #(
  parameter int ADC_W  = 14,
  parameter int BIN_AW = 5,
  parameter int CNT_W  = 20
);
  logic [ADC_W-1:0]  adc;
  logic              adc_valid;
  logic [BIN_AW-1:0] rd_addr;
  logic [CNT_W-1:0]  rd_data;
  logic              rd_valid;

  modport master (output adc, adc_valid, rd_addr, input rd_data, rd_valid);
  modport slave  (input adc, adc_valid, rd_addr, output rd_data, rd_valid);
endinterface

// File: rtl/baseline_hist_tracker.sv
// Baseline-drift histogrammer. ADC samples are binned around a centre value into a
// 2**BIN_AW-bin RAM histogram (end bins collect everything out of range). The mode bin
// is tracked on every write and turned into a baseline estimate. A full bin either halves
// the whole histogram (rescale_en=1) or saturates and raises a sticky flag.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        zero the histogram (synchronous request)
//   pause        stop accumulating, enable readout through bus.rd_addr/rd_data
//   rescale_en   1: halve on full bin, 0: saturate and set filled
//   center_val   histogram centre; a change restarts the histogram
//   bus          sample stream in, readout out (slave side)
//   peak_bin/peak_cnt  current mode bin and its count
//   baseline     centre + bin offset of the mode, clamped to the ADC range
//   filled       sticky saturation flag, cleared by CLEAR
//   busy         clearing or halving; samples are dropped
module baseline_hist_tracker #(
  parameter int ADC_W     = 14,
  parameter int BIN_AW    = 5,
  parameter int CNT_W     = 20,
  parameter int BIN_SHIFT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              pause,
  input  logic              rescale_en,
  input  logic [ADC_W-1:0]  center_val,
  baseline_hist_tracker_if.slave bus,
  output logic [BIN_AW-1:0] peak_bin,
  output logic [CNT_W-1:0]  peak_cnt,
  output logic [ADC_W-1:0]  baseline,
  output logic              filled,
  output logic              busy
);

  localparam int NBINS  = 2**BIN_AW;
  localparam int STAGES = 1;                       // vld_pipe[0]=S0 bin reg, [1]=S1 read done
  localparam int DW     = ADC_W + 2;               // sample difference plus bin offset headroom
  localparam int BW     = ADC_W + BIN_AW + BIN_SHIFT + 2;
  localparam logic [CNT_W-1:0]  CMAX = '1;
  localparam logic [BIN_AW-1:0] MID  = {1'b1, {(BIN_AW-1){1'b0}}};

  localparam logic [2:0] ST_CLEAR = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_HALVE = 3'd4;

  logic [2:0]        state, state_nxt;
  logic [BIN_AW-1:0] clr_cnt;
  logic              drn_cnt;
  logic [ADC_W-1:0]  center_q;

  logic [STAGES:0]   vld_pipe;
  logic [BIN_AW-1:0] s0_bin, s1_bin;
  logic [CNT_W-1:0]  s1_cnt;
  logic [CNT_W-1:0]  wr_inc;
  logic              full_evt;

  logic [BIN_AW:0]   hcnt;
  logic              hv1, hv2;
  logic [BIN_AW-1:0] ha1, ha2;
  logic [CNT_W-1:0]  hr_q, hs_q;
  logic              sweep_on, hdone, restart;

  logic [CNT_W-1:0]  mem [NBINS];

  // ---------------------------------------------------------------- bin map
  logic signed [DW-1:0] diff, dsh, bsum;
  logic [BIN_AW-1:0]    bin_c;

  always_comb begin
    diff = $signed({2'b00, bus.adc}) - $signed({2'b00, center_q});
    dsh  = diff >>> BIN_SHIFT;
    bsum = dsh + $signed(DW'(NBINS/2));
    if (bsum[DW-1])                          bin_c = '0;
    else if (bsum > $signed(DW'(NBINS-1)))   bin_c = '1;
    else                                     bin_c = bsum[BIN_AW-1:0];
  end

  // ---------------------------------------------------------------- baseline
  logic signed [BW-1:0] off_s, sum_s;

  always_comb begin
    off_s = $signed(BW'(peak_bin)) - $signed(BW'(NBINS/2));
    sum_s = $signed(BW'(center_q)) + (off_s <<< BIN_SHIFT);
    if (sum_s[BW-1])                                baseline = '0;
    else if (sum_s > $signed(BW'({ADC_W{1'b1}})))   baseline = '1;
    else                                            baseline = sum_s[ADC_W-1:0];
  end

  // ---------------------------------------------------------------- control
  // Increment saturates so a bin already at CMAX (saturate mode, or a straggler
  // flushed into HALVE) never wraps.
  assign wr_inc   = (s1_cnt == CMAX) ? CMAX : s1_cnt + 1'b1;
  assign full_evt = vld_pipe[STAGES] && (wr_inc == CMAX);
  assign restart  = clear || (center_val != center_q);
  // Halving starts only once in-flight samples have landed.
  assign sweep_on = (state == ST_HALVE) && (vld_pipe == '0);
  assign hdone    = sweep_on && (hcnt == (BIN_AW+1)'(NBINS+1));
  assign busy     = (state == ST_CLEAR) || (state == ST_HALVE);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (clr_cnt == '1) state_nxt = ST_RUN;
      ST_RUN: begin
        if (restart)                      state_nxt = ST_CLEAR;
        else if (full_evt && rescale_en)  state_nxt = ST_HALVE;
        else if (pause)                   state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // a draining write may still fill a bin; halve before readout
        if (restart)                      state_nxt = ST_CLEAR;
        else if (full_evt && rescale_en)  state_nxt = ST_HALVE;
        else if (drn_cnt)                 state_nxt = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (restart)                      state_nxt = ST_CLEAR;
        else if (!pause)                  state_nxt = ST_RUN;
      end
      ST_HALVE: begin
        if (restart)                      state_nxt = ST_CLEAR;
        else if (hdone)                   state_nxt = ST_RUN;
      end
      default:                            state_nxt = ST_CLEAR;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_CLEAR;
      clr_cnt     <= '0;
      drn_cnt     <= 1'b0;
      center_q    <= '0;
      vld_pipe    <= '0;
      s0_bin      <= '0;
      s1_bin      <= '0;
      s1_cnt      <= '0;
      hcnt        <= '0;
      hv1         <= 1'b0;
      hv2         <= 1'b0;
      ha1         <= '0;
      ha2         <= '0;
      hr_q        <= '0;
      hs_q        <= '0;
      peak_bin    <= MID;
      peak_cnt    <= '0;
      filled      <= 1'b0;
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      state <= state_nxt;

      // sample pipeline: S0 bin reg -> S1 RAM read -> write at the following edge
      if (state_nxt == ST_CLEAR) vld_pipe <= '0;
      else vld_pipe <= {vld_pipe[STAGES-1:0], bus.adc_valid && (state == ST_RUN)};
      s0_bin <= bin_c;
      s1_bin <= s0_bin;
      // The only stale read is the bin being written this same edge; older writes
      // are already in the RAM, so one forward covers every hit pattern.
      s1_cnt <= (vld_pipe[STAGES] && (s1_bin == s0_bin)) ? wr_inc : mem[s0_bin];

      clr_cnt <= (state == ST_CLEAR) ? clr_cnt + 1'b1 : '0;
      drn_cnt <= (state == ST_DRAIN) ? ~drn_cnt : 1'b0;

      if (state == ST_CLEAR) begin
        center_q <= center_val;
        peak_bin <= MID;
        peak_cnt <= '0;
        filled   <= 1'b0;
      end else begin
        // incumbent keeps ties; its own bin always refreshes the count
        if (vld_pipe[STAGES] && ((wr_inc > peak_cnt) || (s1_bin == peak_bin))) begin
          peak_bin <= s1_bin;
          peak_cnt <= wr_inc;
        end else if (hdone) begin
          peak_cnt <= peak_cnt >> 1;
        end
        if (full_evt && !rescale_en) filled <= 1'b1;
      end

      // halve sweep: read bin k, shift, write back two cycles later
      hcnt <= (sweep_on && !hdone) ? hcnt + 1'b1 : '0;
      hv1  <= sweep_on && (hcnt < (BIN_AW+1)'(NBINS));
      ha1  <= hcnt[BIN_AW-1:0];
      hr_q <= mem[hcnt[BIN_AW-1:0]];
      hv2  <= sweep_on && hv1;
      ha2  <= ha1;
      hs_q <= hr_q >> 1;

      if (state == ST_PAUSE) bus.rd_data <= mem[bus.rd_addr];
      bus.rd_valid <= (state == ST_PAUSE) && (state_nxt == ST_PAUSE);
    end
  end

  // single write port: clear sweep, sample increment, halve write-back
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR)                mem[clr_cnt] <= '0;
    else if (vld_pipe[STAGES])            mem[s1_bin]  <= wr_inc;
    else if ((state == ST_HALVE) && hv2)  mem[ha2]     <= hs_q;
  end

endmodule

// File: tb/tb_baseline_hist_tracker.sv
module tb_baseline_hist_tracker;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear = 1'b0, pause = 1'b0, rescale_en = 1'b1;
  logic [13:0] center_val = 14'd1000;
  logic [13:0] adc = '0;
  logic        adc_valid = 1'b0;
  logic [4:0]  rd_addr = '0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // a: defaults, b: BIN_SHIFT=2, c: CNT_W=4; all share the stimulus
  baseline_hist_tracker_if #(.ADC_W(14), .BIN_AW(5), .CNT_W(20)) if_a ();
  baseline_hist_tracker_if #(.ADC_W(14), .BIN_AW(5), .CNT_W(20)) if_b ();
  baseline_hist_tracker_if #(.ADC_W(14), .BIN_AW(5), .CNT_W(4))  if_c ();

  assign if_a.adc = adc;  assign if_a.adc_valid = adc_valid;  assign if_a.rd_addr = rd_addr;
  assign if_b.adc = adc;  assign if_b.adc_valid = adc_valid;  assign if_b.rd_addr = rd_addr;
  assign if_c.adc = adc;  assign if_c.adc_valid = adc_valid;  assign if_c.rd_addr = rd_addr;

  logic [4:0]  pk_bin_a, pk_bin_b, pk_bin_c;
  logic [19:0] pk_cnt_a, pk_cnt_b;
  logic [3:0]  pk_cnt_c;
  logic [13:0] base_a, base_b, base_c;
  logic        filled_a, filled_b, filled_c, busy_a, busy_b, busy_c;

  baseline_hist_tracker #(.ADC_W(14), .BIN_AW(5), .CNT_W(20), .BIN_SHIFT(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .pause(pause), .rescale_en(rescale_en),
    .center_val(center_val), .bus(if_a), .peak_bin(pk_bin_a), .peak_cnt(pk_cnt_a),
    .baseline(base_a), .filled(filled_a), .busy(busy_a));

  baseline_hist_tracker #(.ADC_W(14), .BIN_AW(5), .CNT_W(20), .BIN_SHIFT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .pause(pause), .rescale_en(rescale_en),
    .center_val(center_val), .bus(if_b), .peak_bin(pk_bin_b), .peak_cnt(pk_cnt_b),
    .baseline(base_b), .filled(filled_b), .busy(busy_b));

  baseline_hist_tracker #(.ADC_W(14), .BIN_AW(5), .CNT_W(4), .BIN_SHIFT(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .clear(clear), .pause(pause), .rescale_en(rescale_en),
    .center_val(center_val), .bus(if_c), .peak_bin(pk_bin_c), .peak_cnt(pk_cnt_c),
    .baseline(base_c), .filled(filled_c), .busy(busy_c));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // one sample per call; consecutive calls are back-to-back
  task automatic send(input logic [13:0] v);
    adc = v; adc_valid = 1'b1;
    @(negedge clk);
    adc_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    idle(40);
  endtask

  task automatic enter_pause();
    pause = 1'b1; idle(5);
  endtask

  task automatic leave_pause();
    pause = 1'b0; idle(2);
  endtask

  task automatic rd(input logic [4:0] a);
    rd_addr = a; @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst_n = 1'b0;
    idle(3);
    chk("rst_busy",     busy_a, 1);
    chk("rst_peak_bin", pk_bin_a, 16);
    chk("rst_peak_cnt", pk_cnt_a, 0);
    chk("rst_rd_data",  if_a.rd_data, 0);
    chk("rst_rd_valid", if_a.rd_valid, 0);
    chk("rst_filled",   filled_a, 0);
    rst_n = 1'b1;
    cnt = 0;
    while (busy_a && cnt < 100) begin @(negedge clk); cnt++; end
    chk("clear_len", cnt, 32);
    idle(4);

    // single bin, offset +3
    rd_addr = 5'd19;
    for (int i = 0; i < 10; i++) send(14'd1003);
    enter_pause();
    chk("t1_rd_valid", if_a.rd_valid, 1);
    chk("t1_bin19",    if_a.rd_data, 10);
    chk("t1_peak_bin", pk_bin_a, 19);
    chk("t1_peak_cnt", pk_cnt_a, 10);
    chk("t1_baseline", base_a, 1003);
    leave_pause();
    chk("t1_rd_valid_off", if_a.rd_valid, 0);
    do_clear();

    // alternating bins then same-bin run: read-modify-write hazards
    for (int i = 0; i < 8; i++) send((i % 2) ? 14'd1001 : 14'd1000);
    for (int i = 0; i < 3; i++) send(14'd1000);
    enter_pause();
    rd(5'd16); chk("t2_bin16", if_a.rd_data, 7);
    rd(5'd17); chk("t2_bin17", if_a.rd_data, 4);
    rd(5'd18); chk("t2_bin18", if_a.rd_data, 0);
    chk("t2_peak_bin", pk_bin_a, 16);
    chk("t2_peak_cnt", pk_cnt_a, 7);
    leave_pause();

    // wide bins and overflow bins (centre change restarts the histogram)
    center_val = 14'd500;
    idle(40);
    send(14'd0); send(14'd16383); send(14'd507);
    enter_pause();
    rd(5'd0);  chk("t3_b_bin0", if_b.rd_data, 1);  chk("t3_a_bin0", if_a.rd_data, 1);
    rd(5'd31); chk("t3_b_bin31", if_b.rd_data, 1); chk("t3_a_bin31", if_a.rd_data, 1);
    rd(5'd17); chk("t3_b_bin17", if_b.rd_data, 1);
    rd(5'd23); chk("t3_a_bin23", if_a.rd_data, 1);
    chk("t3_b_peak_bin", pk_bin_b, 0);
    chk("t3_b_baseline", base_b, 436);
    leave_pause();

    // baseline below zero clamps
    center_val = 14'd5;
    idle(40);
    send(14'd0);
    idle(4);
    chk("clamp_b_peak_bin", pk_bin_b, 14);
    chk("clamp_b_baseline", base_b, 0);
    chk("clamp_a_baseline", base_a, 0);

    // rescale on full bin (dut_c, CMAX=15)
    center_val = 14'd1000; rescale_en = 1'b1;
    idle(40);
    for (int i = 0; i < 15; i++) send(14'd1000);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (busy_c) cnt++;
      @(negedge clk);
    end
    chk("t4_halve_len", cnt, 34);
    enter_pause();
    rd(5'd16); chk("t4_c_bin16", if_c.rd_data, 7); chk("t4_a_bin16", if_a.rd_data, 15);
    chk("t4_c_peak_cnt", pk_cnt_c, 7);
    chk("t4_c_peak_bin", pk_bin_c, 16);
    chk("t4_c_filled",   filled_c, 0);
    leave_pause();

    // saturate mode
    rescale_en = 1'b0;
    do_clear();
    for (int i = 0; i < 20; i++) send(14'd989);
    enter_pause();
    rd(5'd5); chk("t5_c_bin5", if_c.rd_data, 15); chk("t5_a_bin5", if_a.rd_data, 20);
    chk("t5_c_filled",   filled_c, 1);
    chk("t5_a_filled",   filled_a, 0);
    chk("t5_c_peak_cnt", pk_cnt_c, 15);
    leave_pause();
    idle(10);
    chk("t5_filled_hold", filled_c, 1);
    do_clear();
    chk("t5_filled_clr", filled_c, 0);

    // centre change mid-stream
    rescale_en = 1'b1;
    for (int i = 0; i < 3; i++) send(14'd1000);
    center_val = 14'd1001;
    send(14'd1000);
    chk("t6_busy", busy_a, 1);
    send(14'd1000);
    idle(40);
    enter_pause();
    rd(5'd16); chk("t6_bin16", if_a.rd_data, 0);
    rd(5'd15); chk("t6_bin15", if_a.rd_data, 0);
    chk("t6_peak_bin", pk_bin_a, 16);
    chk("t6_peak_cnt", pk_cnt_a, 0);
    leave_pause();

    // reset during HALVE
    for (int i = 0; i < 15; i++) send(14'd1001);
    idle(10);
    chk("t7_c_in_halve", busy_c, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t7_c_busy",     busy_c, 1);
    chk("t7_c_peak_bin", pk_bin_c, 16);
    chk("t7_c_peak_cnt", pk_cnt_c, 0);
    rst_n = 1'b1;
    idle(40);
    enter_pause();
    rd(5'd16); chk("t7_c_bin16", if_c.rd_data, 0); chk("t7_a_bin16", if_a.rd_data, 0);
    chk("t7_a_peak_cnt", pk_cnt_a, 0);
    leave_pause();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
